// File: rtl/seq_detector_param.sv
// Serial bit-sequence detector with loadable pattern, selectable overlap
// policy, input qualification and a saturating match counter.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   din_valid  qualifies din; bits are accepted only when high
//   din        serial data bit
//   overlap    1 = overlapping detection, 0 = non-overlapping
//   pat_load   load pat_in into the pattern register (din ignored)
//   pat_in     new pattern, MSB is the first bit received
//   clr_cnt    synchronous clear of match_cnt (wins over a match)
//   dout       registered one-cycle match pulse
//   match_cnt  saturating match count
//   pattern    current pattern register
module seq_detector_param #(
    parameter int                 SEQ_LEN = 5,
    parameter logic [SEQ_LEN-1:0] PATTERN = 5'b10101,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_valid,
    input  logic               din,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [SEQ_LEN-1:0] pat_in,
    input  logic               clr_cnt,
    output logic               dout,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [SEQ_LEN-1:0] pattern
);

    localparam int               FW       = $clog2(SEQ_LEN);
    localparam logic [FW-1:0]    FILL_MAX = FW'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SEQ_LEN-1:0] pat_q, pat_d;
    logic [SEQ_LEN-2:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dout_q, dout_d;

    logic               accept;
    logic               match;
    logic [SEQ_LEN-1:0] window;

    // Candidate window: stored history with the incoming bit as the LSB.
    assign window = {hist_q, din};
    assign accept = din_valid & ~pat_load;
    assign match  = accept && (fill_q == FILL_MAX) && (window == pat_q);

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        dout_d = match;

        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            if (match && !overlap) begin
                // Non-overlapping: the next match needs a full fresh window.
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[SEQ_LEN-2:0];
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FW'(1);
                end
            end
        end

        if (clr_cnt) begin
            cnt_d = '0;
        end else if (match && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout      = dout_q;
    assign match_cnt = cnt_q;
    assign pattern   = pat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed vector table,
// hand-written corner sequences and randomized stimulus against a model.
module tb_seq_detector_param;

    localparam logic [4:0] DEF_PAT = 5'b10101;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din_valid = 1'b0;
    logic       din = 1'b0;
    logic       overlap = 1'b0;
    logic       pat_load = 1'b0;
    logic [4:0] pat_in = '0;
    logic       clr_cnt = 1'b0;

    logic       dout, dout2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
    logic [4:0] pattern, pattern2;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .dout(dout), .match_cnt(match_cnt),
        .pattern(pattern)
    );

    seq_detector_param #(.SEQ_LEN(5), .PATTERN(5'b10101), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .dout(dout2), .match_cnt(match_cnt2),
        .pattern(pattern2)
    );

    // Reference model: list of accepted bits since the last restart,
    // oldest first; true count of matches since the last clear.
    bit         mq[$];
    int         mcnt;
    logic [4:0] mpat;
    bit         mdout;

    function automatic void model_reset();
        mq.delete();
        mcnt  = 0;
        mpat  = DEF_PAT;
        mdout = 1'b0;
    endfunction

    function automatic void model_edge(bit v, bit d, bit ov, bit ld,
                                       logic [4:0] pi, bit clr);
        logic [4:0] last;
        mdout = 1'b0;
        if (ld) begin
            mpat = pi;
            mq.delete();
        end else if (v) begin
            mq.push_back(d);
            if (mq.size() == 5) begin
                last = '0;
                foreach (mq[i]) last = {last[3:0], mq[i]};
                if (last == mpat) begin
                    mdout = 1'b1;
                    mcnt++;
                    if (!ov) mq.delete();
                end
            end
            if (mq.size() > 4) void'(mq.pop_front());
        end
        if (clr) mcnt = 0;
    endfunction

    function automatic int sat(int c, int mx);
        return (c > mx) ? mx : c;
    endfunction

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp,
                     $time);
        end
    endfunction

    task automatic cmp_model(string tag);
        chk({tag, ".dout"}, int'(dout), int'(mdout));
        chk({tag, ".cnt"}, int'(match_cnt), sat(mcnt, 255));
        chk({tag, ".pat"}, int'(pattern), int'(mpat));
        chk({tag, ".dout2"}, int'(dout2), int'(mdout));
        chk({tag, ".cnt2"}, int'(match_cnt2), sat(mcnt, 3));
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(bit v, bit d, bit ov, bit ld, logic [4:0] pi,
                        bit clr, string tag);
        din_valid = v;
        din       = d;
        overlap   = ov;
        pat_load  = ld;
        pat_in    = pi;
        clr_cnt   = clr;
        @(posedge clk);
        model_edge(v, d, ov, ld, pi, clr);
        #1;
        cmp_model(tag);
        @(negedge clk);
    endtask

    // Asserts rst between edges so its effect is checked before any edge.
    task automatic do_reset();
        din_valid = 1'b0;
        pat_load  = 1'b0;
        clr_cnt   = 1'b0;
        rst       = 1'b1;
        #1;
        chk("rst.dout", int'(dout), 0);
        chk("rst.cnt", int'(match_cnt), 0);
        chk("rst.pat", int'(pattern), int'(DEF_PAT));
        chk("rst.cnt2", int'(match_cnt2), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         rb;
        bit         v;
        bit         d;
        bit         ov;
        bit         ld;
        logic [4:0] pi;
        bit         clr;
        bit         e_dout;
        int         e_cnt;
        logic [4:0] e_pat;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rb, bit v, bit d, bit ov, bit ld,
                                logic [4:0] pi, bit e_dout, int e_cnt,
                                logic [4:0] e_pat);
        vec_t x;
        x.rb = rb; x.v = v; x.d = d; x.ov = ov; x.ld = ld; x.pi = pi;
        x.clr = 1'b0; x.e_dout = e_dout; x.e_cnt = e_cnt; x.e_pat = e_pat;
        tbl.push_back(x);
    endfunction

    initial begin
        bit s9[9];
        bit bits6[6];
        bit d_nov[9];
        bit d_ov[9];
        int c_nov[9];
        int c_ov[9];
        int pulses;

        s9    = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
        d_nov = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        c_nov = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
        d_ov  = '{0, 0, 0, 0, 1, 0, 1, 0, 1};
        c_ov  = '{0, 0, 0, 0, 1, 1, 2, 2, 3};
        bits6 = '{1, 1, 0, 1, 0, 1};

        // Non-overlapping on the alternating stream.
        for (int i = 0; i < 9; i++)
            add(i == 0, 1, s9[i], 0, 0, 0, d_nov[i], c_nov[i], DEF_PAT);
        // Overlapping on the same stream.
        for (int i = 0; i < 9; i++)
            add(i == 0, 1, s9[i], 1, 0, 0, d_ov[i], c_ov[i], DEF_PAT);
        // Qualification gap of 3 cycles after bit 3 (din=1 is ignored).
        for (int i = 0; i < 3; i++)
            add(i == 0, 1, bits6[i], 0, 0, 0, 0, 0, DEF_PAT);
        for (int i = 0; i < 3; i++)
            add(0, 0, 1, 0, 0, 0, 0, 0, DEF_PAT);
        for (int i = 3; i < 6; i++)
            add(0, 1, bits6[i], 0, 0, 0, i == 5, i == 5 ? 1 : 0, DEF_PAT);
        // Load 11111 with a valid 1 on the load edge, then run of 1s.
        add(1, 1, 1, 1, 1, 5'b11111, 0, 0, 5'b11111);
        for (int i = 1; i <= 7; i++)
            add(0, 1, 1, 1, 0, 0, i >= 5, i >= 5 ? i - 4 : 0, 5'b11111);

        @(negedge clk);
        foreach (tbl[k]) begin
            if (tbl[k].rb) do_reset();
            step(tbl[k].v, tbl[k].d, tbl[k].ov, tbl[k].ld, tbl[k].pi,
                 tbl[k].clr, "tbl");
            chk("tbl.e_dout", int'(dout), int'(tbl[k].e_dout));
            chk("tbl.e_cnt", int'(match_cnt), tbl[k].e_cnt);
            chk("tbl.e_pat", int'(pattern), int'(tbl[k].e_pat));
        end

        // Saturation of the narrow counter, then clear on a match edge.
        do_reset();
        step(0, 0, 1, 1, 5'b11111, 0, "sat.ld");
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 0, "sat.run");
        chk("sat.cnt2_hold", int'(match_cnt2), 3);
        chk("sat.cnt8", int'(match_cnt), 6);
        step(1, 1, 1, 0, 0, 1, "clr");
        chk("clr.dout", int'(dout), 1);
        chk("clr.cnt", int'(match_cnt), 0);
        chk("clr.cnt2", int'(match_cnt2), 0);
        step(1, 1, 1, 0, 0, 0, "clr.after");
        chk("clr.after_cnt", int'(match_cnt), 1);

        // Reset while dout is high clears it at once.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, s9[i], 0, 0, 0, 0, "rs.a");
        chk("rs.pre_dout", int'(dout), 1);
        do_reset();

        // Reset mid-stream discards partial history.
        for (int i = 0; i < 4; i++) step(1, s9[i], 0, 0, 0, 0, "rs.b");
        do_reset();
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, s9[i], 0, 0, 0, 0, "rs.c");
            if (dout) pulses++;
            if (i == 0) chk("rs.first_bit", int'(dout), 0);
        end
        chk("rs.pulse5", int'(dout), 1);
        chk("rs.pulses", pulses, 1);

        // Randomized stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            bit         v, d, ov, ld, clr;
            logic [4:0] pi;
            if ($urandom_range(0, 199) == 0) do_reset();
            v   = $urandom_range(0, 3) != 0;
            d   = $urandom_range(0, 1) == 1;
            ov  = (n / 97) % 2 == 1;
            ld  = $urandom_range(0, 59) == 0;
            clr = $urandom_range(0, 39) == 0;
            case ($urandom_range(0, 3))
                0: pi = 5'b10101;
                1: pi = 5'b11111;
                2: pi = 5'b11011;
                default: pi = 5'($urandom);
            endcase
            step(v, d, ov, ld, pi, clr, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-sequence detector with a loadable pattern, selectable overlapping or non-overlapping detection, input qualification and a saturating match counter. It sits on a single-bit serial stream next to the fixed-pattern detectors and replaces them wherever the pattern, its length or the overlap policy must vary per instance or at run time. The detector output is registered, one pulse per detected occurrence.

## Interface
- SEQ_LEN, 5, pattern length in bits; legal range 2..32
- PATTERN, 5'b10101, reset and default pattern, SEQ_LEN bits wide; the MSB is the first bit received
- CNT_W, 8, width of match_cnt; legal range 1..32
- clk  input  1  single clock; all logic is on its rising edge
- rst  input  1  asynchronous, active-high reset
- din_valid  input  1  din is sampled only when this is high
- din  input  1  serial data bit
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection
- pat_load  input  1  load pat_in into the pattern register
- pat_in  input  SEQ_LEN  new pattern; MSB is the first bit received
- clr_cnt  input  1  synchronous clear of match_cnt
- dout  output  1  registered match pulse
- match_cnt  output  CNT_W  saturating count of matches
- pattern  output  SEQ_LEN  current pattern register contents

## Operation
- Internal state:
  - pattern register pat[SEQ_LEN-1:0].
  - history shift register hist[SEQ_LEN-2:0], holding the most recently accepted bits, newest in the LSB.
  - fill counter fill, range 0..SEQ_LEN-1: the number of valid bits held in hist.
- Accepted bit: a clock edge where din_valid=1 and pat_load=0.
- Match condition on an accepted bit: fill == SEQ_LEN-1 and {hist, din} == pat.
- Each accepted bit updates state as follows:
  - hist shifts left with din entering the LSB.
  - fill increments, saturating at SEQ_LEN-1.
  - On a match with overlap=1, hist and fill update normally, so the suffix of the match can seed the next match.
  - On a match with overlap=0, hist is cleared to 0 and fill to 0. The next match needs SEQ_LEN fresh bits.
- dout:
  - Set to 1 on the edge that accepts the matching bit.
  - Set to 0 on every other edge, including edges with din_valid=0.
  - Back-to-back pulses are legal in overlap mode when the pattern allows it (for example 11...1).
- match_cnt:
  - Increments by 1 on every match.
  - Saturates at 2^CNT_W-1 and never wraps.
- clr_cnt=1 sets match_cnt to 0. If a match occurs on the same edge, the clear wins and match_cnt=0; dout still pulses.
- pat_load=1 on an edge:
  - pat <= pat_in; hist and fill are cleared; dout <= 0.
  - din is ignored on that edge even when din_valid=1.
  - match_cnt is unaffected, unless clr_cnt is also high.
- An overlap change takes effect on the next accepted bit. hist and fill are retained across the change.
- din_valid=0 holds hist, fill, pat and match_cnt unchanged.

## Timing
- Reset, asynchronous, immediate on rst rising:
  - dout=0, match_cnt=0, pattern=PATTERN.
  - hist=0, fill=0.
- While rst is high, all inputs are ignored.
- First edge after rst deasserts is a normal edge.
- Latency:
  - dout is high during the cycle following the edge that samples the final pattern bit. This is one register stage.
  - match_cnt updates on that same edge.
  - pattern reflects pat_in in the cycle following the pat_load edge.
- Reset asserted mid-stream discards the partial history. A match can only occur after SEQ_LEN accepted bits following reset.
- No handshake back-pressure: every accepted bit is consumed on its edge.

## Test plan
- Defaults, overlap=0, din_valid=1, stream 1,0,1,0,1,0,1,0,1 -> dout pulses once, in the cycle after bit 5; match_cnt=1.
- Same stream with overlap=1 -> dout pulses after bits 5, 7 and 9; match_cnt=3.
- Stream 1,1,0,1,0,1 with din_valid=0 inserted for 3 cycles between bits 3 and 4 -> exactly one pulse, after bit 6; dout=0 during the gap; match_cnt=1.
- pat_load with pat_in=5'b11111 while din_valid=1, din=1, then five 1s with overlap=1 -> pattern=11111 in the next cycle; the load-edge bit is ignored; pulses after the 5th 1 and on every subsequent 1.
- CNT_W=2, overlap=1, pattern 11111, continuous 1s -> match_cnt reaches 3 and holds at 3. clr_cnt on a match edge -> match_cnt=0 with dout=1 in the same cycle.
- Assert rst after 1,0,1,0 have been accepted, then release and send 1,0,1,0,1 -> dout=0 and match_cnt=0 immediately on rst; the first pulse comes after the 5th post-reset bit, with no pulse on the first post-reset 1.
